eth_rx_payload_packer: RTL and testbench
========================================

Name: eth_rx_payload_packer

Overview:
- Consumes the raw Ethernet frame byte stream (dest MAC, src MAC, EtherType, payload) leaving the Ethernet connection stage.
- Checks the EtherType, strips the 14-byte header, and packs payload bytes into 32-bit words on an AXI-Stream-style output for the downstream application logic.
- Reports per-frame length and error or drop status.

Parameters:
- ETHERTYPE, 16'h88B5, EtherType accepted when filtering is enabled.
- FILTER_EN, 1, 1 = drop frames whose EtherType differs from ETHERTYPE; 0 = accept all.
- MAX_PAYLOAD, 1500, payload byte limit; bytes beyond it are discarded.

Ports:
- i_clk  in  1  system clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- i_s_valid  in  1  input byte valid
- i_s_data  in  8  input byte
- i_s_last  in  1  last byte of frame
- o_s_ready  out  1  input ready (drives i_eth_rx_ready upstream)
- o_m_valid  out  1  output word valid
- o_m_data  out  32  packed payload; first byte in [7:0]
- o_m_keep  out  4  byte enables; bit n covers byte lane n
- o_m_last  out  1  last word of frame payload
- i_m_ready  in  1  downstream ready
- o_frame_done  out  1  one-cycle pulse when an accepted frame completes
- o_frame_len  out  11  payload byte count of the completed frame; valid with o_frame_done
- o_frame_drop  out  1  one-cycle pulse when a frame is filtered out
- o_err_runt  out  1  one-cycle pulse: frame ended inside the header
- o_err_oversize  out  1  one-cycle pulse: payload exceeded MAX_PAYLOAD

Behaviour:
- Reset: all outputs 0, state HDR, header count 0, accumulator empty. Asserting rst_n low mid-frame discards everything, including a pending output word.
- Input transfer occurs when i_s_valid && o_s_ready. Output transfer occurs when o_m_valid && i_m_ready.
- Output hold rule: o_m_valid, o_m_data, o_m_keep and o_m_last stay stable until accepted.
- o_s_ready:
  - 1 in HDR and DROP.
  - In PAYLOAD: !o_m_valid || i_m_ready (a single output register; the accumulator never stalls independently).
- States:
  - HDR
    - Count bytes 0..13; capture bytes 12 and 13 as the EtherType, big-endian.
    - On byte 13 with i_s_last = 0: if FILTER_EN and the type mismatches, go to DROP; else go to PAYLOAD.
    - On byte 13 with i_s_last = 1 and the type matching: o_frame_done pulses with len = 0, no word is emitted, stay in HDR.
    - i_s_last before byte 13: pulse o_err_runt, reset count, stay in HDR, no output.
  - PAYLOAD
    - Shift each byte into lane (count mod 4).
    - On the 4th lane, or on i_s_last, load the output register the next cycle with keep equal to the filled lanes, contiguous from lane 0.
    - o_m_last = i_s_last.
    - On last: o_frame_done and o_frame_len pulse in the same cycle the last word loads; return to HDR.
  - DROP
    - Accept and discard bytes until i_s_last.
    - Pulse o_frame_drop on the last byte; return to HDR.
- Latency: 1 cycle from accepting the completing byte to o_m_valid.
- Oversize: when byte MAX_PAYLOAD is accepted without i_s_last:
  - That word is emitted with o_m_last = 1.
  - o_err_oversize pulses, and o_frame_done pulses with len = MAX_PAYLOAD.
  - State moves to DROP without pulsing o_frame_drop at its end.
- o_frame_len is an 11-bit counter, saturating at MAX_PAYLOAD, held after the done pulse until the next done.
- A back-to-back frame can begin in HDR on the cycle after last; no bubble is required.
- A lone i_s_valid glitch with i_s_last in DROP ends the drop normally.

Decomposition:
- Package eth_pkg: ETH_HDR_LEN = 14, ETH_TYPE_OFFSET = 12, the state enum (HDR, PAYLOAD, DROP), and the default EtherType constant.
- Sub-module byte_to_word_packer: lane accumulator, keep generation, and the output register with its ready/valid handshake.
- The top-level module holds the header FSM, filter and status logic.

Test Plan:
- Frame with type 88B5 and an 8-byte payload 01..08, i_m_ready = 1:
  - Two words, 0x04030201 with keep F, then 0x08070605 with keep F and last.
  - o_frame_done with len 8.
- Type 88B5 with a 5-byte payload 0A..0E:
  - Word 0x0D0C0B0A with keep F, then word 0x0000000E with keep 1 and last; len 5.
- Type 0800 with FILTER_EN = 1 and a 20-byte payload:
  - No output words; o_frame_drop pulses once on the last byte.
- 10-byte frame (last at byte 9):
  - o_err_runt pulses; no output.
  - The following valid frame is parsed correctly.
- i_m_ready held 0 for 5 cycles during a 12-byte payload:
  - o_s_ready drops and the word is held stable.
  - All 3 words arrive in order with no loss.
- MAX_PAYLOAD = 6 with a 10-byte payload:
  - Words 0x04030201 (keep F) and 0x????0605 (keep 3, last).
  - o_err_oversize pulses and len = 6.
  - The remaining bytes are discarded; rst_n pulsed low mid-frame clears o_m_valid immediately.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive payload path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eth_pkg;

    // Ethernet II header: 6 B dest MAC, 6 B src MAC, 2 B EtherType.
    localparam int ETH_HDR_LEN     = 14;
    localparam int ETH_TYPE_OFFSET = 12;

    // Header byte indices as 4-bit counter values.
    localparam logic [3:0] HDR_TYPE_HI_IDX = 4'(ETH_TYPE_OFFSET);
    localparam logic [3:0] HDR_LAST_IDX    = 4'(ETH_HDR_LEN - 1);

    // EtherType accepted when filtering is on.
    localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;

    // Frame parser states.
    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } rx_state_t;

    // Byte enables for a word whose highest filled lane is 'lane'.
    // Lanes always fill contiguously from lane 0.
    function automatic logic [3:0] keep_mask(input logic [1:0] lane);
        logic [3:0] mask;
        case (lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs an accepted byte stream into 32-bit words, first byte in lane 0.
// Latency: 1 cycle from the completing byte (lane 3 or flush) to m_valid.
// Backpressure: single output register; in_rdy = !m_valid || m_ready.
module byte_to_word_packer
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [7:0]  in_dat,
    input  logic        in_last,
    output logic        in_rdy,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    input  logic        m_ready
);

    logic [1:0]  lane_q;
    logic [31:0] acc_q;
    logic [31:0] word_d;
    logic        flush;

    // The accumulator only advances on bytes the caller already gated with
    // in_rdy, so a word is never produced while the register is still full.
    assign in_rdy = !m_valid || m_ready;
    assign flush  = in_vld && ((lane_q == 2'd3) || in_last);

    // Merge the incoming byte into its lane; unfilled lanes stay zero.
    always_comb begin
        word_d = acc_q;
        word_d[{lane_q, 3'b000} +: 8] = in_dat;
    end

    // Lane accumulator: cleared whenever a word is handed to the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            acc_q  <= 32'd0;
        end else if (in_vld) begin
            if (flush) begin
                lane_q <= 2'd0;
                acc_q  <= 32'd0;
            end else begin
                lane_q <= lane_q + 2'd1;
                acc_q  <= word_d;
            end
        end
    end

    // Output register: loads on flush, holds until the downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 32'd0;
            m_keep  <= 4'd0;
            m_last  <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b1;
            m_data  <= word_d;
            m_keep  <= keep_mask(lane_q);
            m_last  <= in_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_rx_payload_packer.sv
// Strips the Ethernet header, filters on EtherType, packs payload into 32-bit words.
// Latency: 1 cycle from the completing payload byte to o_m_valid; status pulses align with it.
// Backpressure: o_s_ready always 1 in HDR/DROP; in PAYLOAD follows the output register.
module eth_rx_payload_packer
    import eth_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE   = ETH_TYPE_DEFAULT,
    parameter bit          FILTER_EN   = 1'b1,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic        i_s_valid,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_last,
    output logic        o_s_ready,
    output logic        o_m_valid,
    output logic [31:0] o_m_data,
    output logic [3:0]  o_m_keep,
    output logic        o_m_last,
    input  logic        i_m_ready,
    output logic        o_frame_done,
    output logic [10:0] o_frame_len,
    output logic        o_frame_drop,
    output logic        o_err_runt,
    output logic        o_err_oversize
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);

    rx_state_t   state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [10:0] pay_cnt_q, pay_cnt_d;
    logic [10:0] len_d;
    logic        trunc_q, trunc_d;
    logic        done_d, drop_d, runt_d, over_d;

    logic        accept;
    logic        pk_vld, pk_last, pk_rdy;
    logic [15:0] rx_type;
    logic        type_ok;
    logic [10:0] pay_next;

    assign o_s_ready = (state_q != PAYLOAD) || pk_rdy;
    assign accept    = i_s_valid && o_s_ready;
    assign rx_type   = {type_hi_q, i_s_data};
    assign type_ok   = !FILTER_EN || (rx_type == ETHERTYPE);
    assign pay_next  = pay_cnt_q + 11'd1;

    // Next-state, counters and status pulses for the header/payload/drop parser.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        type_hi_d = type_hi_q;
        pay_cnt_d = pay_cnt_q;
        len_d     = o_frame_len;
        trunc_d   = trunc_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        runt_d    = 1'b0;
        over_d    = 1'b0;
        pk_vld    = 1'b0;
        pk_last   = 1'b0;

        case (state_q)
            HDR: begin
                if (accept) begin
                    if (hdr_cnt_q == HDR_TYPE_HI_IDX) begin
                        type_hi_d = i_s_data;
                    end
                    if (i_s_last) begin
                        // Frame ends in the header: either a runt or a header-only frame.
                        hdr_cnt_d = 4'd0;
                        if (hdr_cnt_q == HDR_LAST_IDX) begin
                            if (type_ok) begin
                                done_d = 1'b1;
                                len_d  = 11'd0;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end else begin
                            runt_d = 1'b1;
                        end
                    end else if (hdr_cnt_q == HDR_LAST_IDX) begin
                        hdr_cnt_d = 4'd0;
                        pay_cnt_d = 11'd0;
                        trunc_d   = 1'b0;
                        state_d   = type_ok ? PAYLOAD : DROP;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                    end
                end
            end

            PAYLOAD: begin
                if (accept) begin
                    pk_vld    = 1'b1;
                    pay_cnt_d = pay_next;
                    if (i_s_last) begin
                        pk_last = 1'b1;
                        done_d  = 1'b1;
                        len_d   = pay_next;
                        state_d = HDR;
                    end else if (pay_next == MAX_LEN) begin
                        // Truncate: close the frame downstream, swallow the rest silently.
                        pk_last = 1'b1;
                        done_d  = 1'b1;
                        over_d  = 1'b1;
                        len_d   = MAX_LEN;
                        trunc_d = 1'b1;
                        state_d = DROP;
                    end
                end
            end

            DROP: begin
                if (accept && i_s_last) begin
                    drop_d  = !trunc_q;
                    trunc_d = 1'b0;
                    state_d = HDR;
                end
            end

            default: begin
                state_d   = HDR;
                hdr_cnt_d = 4'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, captured EtherType byte and registered status outputs.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt_q      <= 4'd0;
            type_hi_q      <= 8'd0;
            pay_cnt_q      <= 11'd0;
            trunc_q        <= 1'b0;
            o_frame_len    <= 11'd0;
            o_frame_done   <= 1'b0;
            o_frame_drop   <= 1'b0;
            o_err_runt     <= 1'b0;
            o_err_oversize <= 1'b0;
        end else begin
            hdr_cnt_q      <= hdr_cnt_d;
            type_hi_q      <= type_hi_d;
            pay_cnt_q      <= pay_cnt_d;
            trunc_q        <= trunc_d;
            o_frame_len    <= len_d;
            o_frame_done   <= done_d;
            o_frame_drop   <= drop_d;
            o_err_runt     <= runt_d;
            o_err_oversize <= over_d;
        end
    end

    byte_to_word_packer u_packer (
        .clk     (i_clk),
        .rst_n   (rst_n),
        .in_vld  (pk_vld),
        .in_dat  (i_s_data),
        .in_last (pk_last),
        .in_rdy  (pk_rdy),
        .m_valid (o_m_valid),
        .m_data  (o_m_data),
        .m_keep  (o_m_keep),
        .m_last  (o_m_last),
        .m_ready (i_m_ready)
    );

endmodule

// File: tb/tb_eth_rx_payload_packer.sv
// Directed bench for eth_rx_payload_packer: default instance plus a MAX_PAYLOAD=6 instance.
module tb_eth_rx_payload_packer;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst_n;
    logic        s_valid    [2];
    logic [7:0]  s_data     [2];
    logic        s_last     [2];
    logic        s_ready    [2];
    logic        m_valid    [2];
    logic [31:0] m_data     [2];
    logic [3:0]  m_keep     [2];
    logic        m_last     [2];
    logic        m_ready    [2];
    logic        frame_done [2];
    logic [10:0] frame_len  [2];
    logic        frame_drop [2];
    logic        err_runt   [2];
    logic        err_over   [2];

    eth_rx_payload_packer u_dut0 (
        .i_clk(clk), .rst_n(rst_n),
        .i_s_valid(s_valid[0]), .i_s_data(s_data[0]), .i_s_last(s_last[0]), .o_s_ready(s_ready[0]),
        .o_m_valid(m_valid[0]), .o_m_data(m_data[0]), .o_m_keep(m_keep[0]), .o_m_last(m_last[0]),
        .i_m_ready(m_ready[0]),
        .o_frame_done(frame_done[0]), .o_frame_len(frame_len[0]), .o_frame_drop(frame_drop[0]),
        .o_err_runt(err_runt[0]), .o_err_oversize(err_over[0])
    );

    eth_rx_payload_packer #(.MAX_PAYLOAD(6)) u_dut1 (
        .i_clk(clk), .rst_n(rst_n),
        .i_s_valid(s_valid[1]), .i_s_data(s_data[1]), .i_s_last(s_last[1]), .o_s_ready(s_ready[1]),
        .o_m_valid(m_valid[1]), .o_m_data(m_data[1]), .o_m_keep(m_keep[1]), .o_m_last(m_last[1]),
        .i_m_ready(m_ready[1]),
        .o_frame_done(frame_done[1]), .o_frame_len(frame_len[1]), .o_frame_drop(frame_drop[1]),
        .o_err_runt(err_runt[1]), .o_err_oversize(err_over[1])
    );

    // Observed words {last, keep, data} and event counters, written only by the monitor.
    logic [36:0] wq [2][$];
    int          done_cnt [2];
    int          drop_cnt [2];
    int          runt_cnt [2];
    int          over_cnt [2];
    int          hold_err [2];
    int          srdy_low [2];
    logic [10:0] last_len [2];
    logic        held     [2] = '{1'b0, 1'b0};
    logic [37:0] held_w   [2];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int rd [2]  = '{0, 0};

    // Monitor, mid-cycle: record transfers and pulses, check the output hold rule.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                held[g] = 1'b0;
            end else begin
                if (held[g] && ({m_valid[g], m_last[g], m_keep[g], m_data[g]} !== held_w[g]))
                    hold_err[g]++;
                if (m_valid[g] && m_ready[g])
                    wq[g].push_back({m_last[g], m_keep[g], m_data[g]});
                if (frame_done[g]) begin
                    done_cnt[g]++;
                    last_len[g] = frame_len[g];
                end
                if (frame_drop[g]) drop_cnt[g]++;
                if (err_runt[g])   runt_cnt[g]++;
                if (err_over[g])   over_cnt[g]++;
                if (!s_ready[g])   srdy_low[g]++;
                held[g]   = m_valid[g] && !m_ready[g];
                held_w[g] = {m_valid[g], m_last[g], m_keep[g], m_data[g]};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] word_at(input int g, input int idx);
        if (idx < wq[g].size()) return wq[g][idx];
        return 'x;
    endfunction

    // Present one byte and hold it until the DUT accepts it (bounded).
    task automatic put_byte(input int g, input logic [7:0] b, input logic last);
        int t;
        s_valid[g] = 1'b1;
        s_data[g]  = b;
        s_last[g]  = last;
        t = 0;
        @(negedge clk);
        while (!s_ready[g] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready[g]) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Send 'total' bytes: MACs, EtherType, then payload first, first+1, ...
    task automatic send_frame(input int g, input logic [15:0] etype, input int total,
                              input logic [7:0] first, input bit with_last);
        logic [7:0] b;
        for (int i = 0; i < total; i++) begin
            if (i < 12)       b = 8'hA0 + 8'(i);
            else if (i == 12) b = etype[15:8];
            else if (i == 13) b = etype[7:0];
            else              b = first + 8'(i - 14);
            put_byte(g, b, with_last && (i == total - 1));
        end
        s_valid[g] = 1'b0;
        s_last[g]  = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, r0, o0, s0;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            s_valid[g] = 1'b0;
            s_data[g]  = 8'h00;
            s_last[g]  = 1'b0;
            m_ready[g] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_m_valid0", 64'(m_valid[0]), 64'd0);
        chk("rst_m_valid1", 64'(m_valid[1]), 64'd0);
        chk("rst_frame_done", 64'(frame_done[0]), 64'd0);
        chk("rst_frame_len", 64'(frame_len[0]), 64'd0);
        chk("rst_s_ready", 64'(s_ready[0]), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8-byte payload 01..08.
        send_frame(0, 16'h88B5, 22, 8'h01, 1'b1);
        settle();
        chk("t1_word0", 64'(word_at(0, rd[0])),     {27'd0, 1'b0, 4'hF, 32'h04030201});
        chk("t1_word1", 64'(word_at(0, rd[0] + 1)), {27'd0, 1'b1, 4'hF, 32'h08070605});
        rd[0] += 2;
        chk("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
        chk("t1_len", 64'(last_len[0]), 64'd8);

        // 5-byte payload 0A..0E.
        send_frame(0, 16'h88B5, 19, 8'h0A, 1'b1);
        settle();
        chk("t2_word0", 64'(word_at(0, rd[0])),     {27'd0, 1'b0, 4'hF, 32'h0D0C0B0A});
        chk("t2_word1", 64'(word_at(0, rd[0] + 1)), {27'd0, 1'b1, 4'h1, 32'h0000000E});
        rd[0] += 2;
        chk("t2_len", 64'(last_len[0]), 64'd5);

        // Filtered EtherType, 20-byte payload.
        d0 = done_cnt[0];
        send_frame(0, 16'h0800, 34, 8'h20, 1'b1);
        settle();
        chk("t3_drop_cnt", 64'(drop_cnt[0]), 64'd1);
        chk("t3_no_words", 64'(wq[0].size()), 64'(rd[0]));
        chk("t3_no_done", 64'(done_cnt[0]), 64'(d0));

        // Runt: last at byte 9, then a good 4-byte frame.
        d0 = done_cnt[0];
        send_frame(0, 16'h88B5, 10, 8'h00, 1'b1);
        settle();
        chk("t4_runt_cnt", 64'(runt_cnt[0]), 64'd1);
        chk("t4_no_words", 64'(wq[0].size()), 64'(rd[0]));
        chk("t4_no_done", 64'(done_cnt[0]), 64'(d0));
        send_frame(0, 16'h88B5, 18, 8'hAA, 1'b1);
        settle();
        chk("t4_next_word", 64'(word_at(0, rd[0])), {27'd0, 1'b1, 4'hF, 32'hADACABAA});
        rd[0] += 1;
        chk("t4_next_len", 64'(last_len[0]), 64'd4);

        // 12-byte payload with the downstream stalled for 5 cycles after the first word.
        s0 = srdy_low[0];
        fork
            send_frame(0, 16'h88B5, 26, 8'h11, 1'b1);
            begin
                repeat (17) @(posedge clk);
                #1 m_ready[0] = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_ready[0] = 1'b1;
            end
        join
        settle();
        chk("t5_s_ready_dropped", 64'(srdy_low[0] - s0 >= 4), 64'd1);
        chk("t5_hold_stable", 64'(hold_err[0]), 64'd0);
        chk("t5_word0", 64'(word_at(0, rd[0])),     {27'd0, 1'b0, 4'hF, 32'h14131211});
        chk("t5_word1", 64'(word_at(0, rd[0] + 1)), {27'd0, 1'b0, 4'hF, 32'h18171615});
        chk("t5_word2", 64'(word_at(0, rd[0] + 2)), {27'd0, 1'b1, 4'hF, 32'h1C1B1A19});
        rd[0] += 3;
        chk("t5_len", 64'(last_len[0]), 64'd12);

        // MAX_PAYLOAD = 6 instance, 10-byte payload 01..0A.
        r0 = drop_cnt[1];
        o0 = over_cnt[1];
        send_frame(1, 16'h88B5, 24, 8'h01, 1'b1);
        settle();
        chk("t6_word0", 64'(word_at(1, rd[1])), {27'd0, 1'b0, 4'hF, 32'h04030201});
        chk("t6_word1_low", 64'({word_at(1, rd[1] + 1)[36:32], word_at(1, rd[1] + 1)[15:0]}),
            64'({1'b1, 4'h3, 16'h0605}));
        rd[1] += 2;
        chk("t6_no_extra_words", 64'(wq[1].size()), 64'(rd[1]));
        chk("t6_over_cnt", 64'(over_cnt[1] - o0), 64'd1);
        chk("t6_len", 64'(last_len[1]), 64'd6);
        chk("t6_no_drop", 64'(drop_cnt[1] - r0), 64'd0);

        // Reset mid-frame with a word pending in the output register.
        m_ready[1] = 1'b0;
        send_frame(1, 16'h88B5, 18, 8'h30, 1'b0);
        chk("t7_pending_valid", 64'(m_valid[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_clears_valid", 64'(m_valid[1]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        send_frame(1, 16'h88B5, 18, 8'h40, 1'b1);
        settle();
        chk("t7_after_rst_word", 64'(word_at(1, rd[1])), {27'd0, 1'b1, 4'hF, 32'h43424140});
        chk("t7_after_rst_len", 64'(last_len[1]), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
